// File: rtl/bist_misr_checker.sv
// rtl/bist_misr_checker.sv - MISR response compactor with one-shot golden compare and sticky verdict
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; returns every register to its idle value
//   running    CUT response valid this cycle (compact it)
//   bist_end   test sequence finished; sampled only while compacting
//   cut_out    CUT response vector
//   signature  current MISR contents
//   vec_count  vectors compacted in the current run, saturating at all-ones
//   sig_valid  verdict available, sticky until the next run starts
//   pass/fail  signature matched / missed GOLDEN; both 0 while sig_valid=0
module bist_misr_checker #(
    parameter int                 WIDTH  = 8,
    parameter logic [WIDTH-1:0]   POLY   = 8'h1D,
    parameter logic [WIDTH-1:0]   SEED   = 8'h00,
    parameter logic [WIDTH-1:0]   GOLDEN = 8'h00,
    parameter int                 CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             running,
    input  logic             bist_end,
    input  logic [WIDTH-1:0] cut_out,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] vec_count,
    output logic             sig_valid,
    output logic             pass,
    output logic             fail
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    // Galois-form MISR step: shift left, fold POLY back in when the MSB
    // falls off, then absorb the response vector.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (running) begin
                    sig_d   = misr_step(SEED, cut_out);
                    cnt_d   = CNT_W'(1);
                    state_d = S_COMPACT;
                end
            end
            S_COMPACT: begin
                // A vector arriving together with bist_end is still compacted.
                if (running) begin
                    sig_d = misr_step(sig_q, cut_out);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (bist_end) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                valid_d = 1'b1;
                pass_d  = (sig_q == GOLDEN);
                fail_d  = (sig_q != GOLDEN);
                state_d = S_DONE;
            end
            S_DONE: begin
                // Verdict stays sticky until the controller starts another run.
                if (running) begin
                    valid_d = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    sig_d   = misr_step(SEED, cut_out);
                    cnt_d   = CNT_W'(1);
                    state_d = S_COMPACT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign signature = sig_q;
    assign vec_count = cnt_q;
    assign sig_valid = valid_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

endmodule
